seq_mult: RTL and testbench

Parametrised iterative shift-add multiplier with a start/done handshake and a selectable unsigned/two's-complement mode. It is the clocked successor to the combinational 4×4 array multiplier and occupies the same position in the design: operand switches feed `a`/`b`, and `product` drives the seven-segment decoders. It trades one adder row per operand bit for a single reused adder, so operand width scales with a parameter and costs no extra area per bit.

---
 rtl/seq_mult.sv | 97 +++++++++
 tb/tb_seq_mult.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mult.sv
// Iterative shift-add multiplier: one partial product per cycle through a single reused adder.
// Unsigned or two's-complement operands; the sign is applied to the magnitude product at the end.
module seq_mult #(
   parameter int WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 sgn,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t            state_reg;
   logic [WIDTH-1:0]  ma_reg, mb_reg;
   logic              neg_reg;
   logic [PW-1:0]     acc_reg;
   logic [CW-1:0]     cnt_reg;
   logic [PW-1:0]     product_reg;
   logic              busy_reg, done_reg;

   logic [WIDTH-1:0]  ma_next, mb_next;
   logic              neg_next;
   logic [PW-1:0]     addend, acc_next;
   logic              last_step;

   // Magnitudes of the incoming operands; -2^(WIDTH-1) negates to itself, read as unsigned.
   always_comb begin
      ma_next   = (sgn && a[WIDTH-1]) ? -a : a;
      mb_next   = (sgn && b[WIDTH-1]) ? -b : b;
      neg_next  = sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
      addend    = mb_reg[0] ? ({{WIDTH{1'b0}}, ma_reg} << cnt_reg) : '0;
      acc_next  = acc_reg + addend;
      last_step = (cnt_reg == CW'(WIDTH - 1));
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= IDLE;
         ma_reg      <= '0;
         mb_reg      <= '0;
         neg_reg     <= 1'b0;
         acc_reg     <= '0;
         cnt_reg     <= '0;
         product_reg <= '0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         case (state_reg)
            IDLE, DONE: begin
               done_reg <= 1'b0;
               if (start) begin
                  ma_reg    <= ma_next;
                  mb_reg    <= mb_next;
                  neg_reg   <= neg_next;
                  acc_reg   <= '0;
                  cnt_reg   <= '0;
                  busy_reg  <= 1'b1;
                  state_reg <= RUN;
               end else begin
                  state_reg <= IDLE;
               end
            end
            RUN: begin
               acc_reg <= acc_next;
               mb_reg  <= mb_reg >> 1;
               cnt_reg <= cnt_reg + CW'(1);
               // The final partial product is folded straight into the result register.
               if (last_step) begin
                  product_reg <= neg_reg ? -acc_next : acc_next;
                  busy_reg    <= 1'b0;
                  done_reg    <= 1'b1;
                  state_reg   <= DONE;
               end
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign busy    = busy_reg;
   assign done    = done_reg;
   assign product = product_reg;

endmodule

// File: tb/tb_seq_mult.sv
// Self-checking bench for seq_mult at WIDTH=4 and WIDTH=8 against an arithmetic reference.
module tb_seq_mult;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start4 = 1'b0, sgn4 = 1'b0;
   logic [3:0] a4 = '0, b4 = '0;
   logic       busy4, done4;
   logic [7:0] prod4;
   logic       start8 = 1'b0, sgn8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic       busy8, done8;
   logic [15:0] prod8;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   seq_mult #(.WIDTH(4)) dut4 (
      .clk(clk), .reset(reset), .start(start4), .sgn(sgn4), .a(a4), .b(b4),
      .busy(busy4), .done(done4), .product(prod4)
   );

   seq_mult #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .start(start8), .sgn(sgn8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .product(prod8)
   );

   function automatic logic [7:0] model4(input logic [3:0] x, input logic [3:0] y, input logic s);
      int vx, vy, r;
      vx = s ? int'($signed(x)) : int'(x);
      vy = s ? int'($signed(y)) : int'(y);
      r  = vx * vy;
      return r[7:0];
   endfunction

   function automatic logic [15:0] model8(input logic [7:0] x, input logic [7:0] y, input logic s);
      int vx, vy, r;
      vx = s ? int'($signed(x)) : int'(x);
      vy = s ? int'($signed(y)) : int'(y);
      r  = vx * vy;
      return r[15:0];
   endfunction

   // Called at a negedge; returns at the negedge of the cycle where done is seen.
   task automatic run4(input logic [3:0] x, input logic [3:0] y, input logic s,
                       output logic [7:0] p, output int cyc);
      a4 = x; b4 = y; sgn4 = s; start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      cyc = 1;
      while (!done4 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      p = prod4;
   endtask

   task automatic run8(input logic [7:0] x, input logic [7:0] y, input logic s,
                       output logic [15:0] p, output int cyc);
      a8 = x; b8 = y; sgn8 = s; start8 = 1'b1;
      @(negedge clk);
      start8 = 1'b0;
      cyc = 1;
      while (!done8 && cyc < 30) begin
         @(negedge clk);
         cyc++;
      end
      p = prod8;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (busy4 !== 1'b0 || done4 !== 1'b0 || prod4 !== 8'h00) begin
         failures++;
         $display("FAIL reset_w4 busy=%b done=%b product=%h required 0 0 00", busy4, done4, prod4);
      end
      checks++;
      if (busy8 !== 1'b0 || done8 !== 1'b0 || prod8 !== 16'h0000) begin
         failures++;
         $display("FAIL reset_w8 busy=%b done=%b product=%h required 0 0 0000", busy8, done8, prod8);
      end
      reset = 1'b0;
      @(negedge clk);
      $display("reset released");
   endtask

   task automatic test_latency;
      a4 = 4'd15; b4 = 4'd15; sgn4 = 1'b0; start4 = 1'b1;
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         start4 = 1'b0;
         checks++;
         if (busy4 !== (c <= 4) || done4 !== (c == 5)) begin
            failures++;
            $display("FAIL latency cycle=%0d busy=%b done=%b required busy=%b done=%b",
                     c, busy4, done4, c <= 4, c == 5);
         end
      end
      checks++;
      if (prod4 !== 8'hE1) begin
         failures++;
         $display("FAIL latency_product product=%h required E1", prod4);
      end
      $display("latency 15x15 product=%h", prod4);
   endtask

   task automatic test_unsigned_sweep;
      logic [7:0] p;
      int cyc;
      for (int i = 0; i < 16; i++) begin
         for (int j = 0; j < 16; j++) begin
            run4(4'(i), 4'(j), 1'b0, p, cyc);
            checks++;
            if (p !== model4(4'(i), 4'(j), 1'b0) || cyc != 5) begin
               failures++;
               $display("FAIL unsigned_sweep %0dx%0d product=%h cycle=%0d required %h cycle=5",
                        i, j, p, cyc, model4(4'(i), 4'(j), 1'b0));
            end
         end
         $display("unsigned sweep a=%0d done", i);
      end
   endtask

   task automatic test_signed;
      logic [7:0] p;
      int cyc;
      logic [3:0] xs [3] = '{4'b1101, 4'b1000, 4'b0000};
      logic [3:0] ys [3] = '{4'd5,    4'b1000, 4'b1000};
      logic [7:0] es [3] = '{8'hF1,   8'h40,   8'h00};
      for (int k = 0; k < 3; k++) begin
         run4(xs[k], ys[k], 1'b1, p, cyc);
         checks++;
         if (p !== es[k]) begin
            failures++;
            $display("FAIL signed_vector a=%b b=%b product=%h required %h", xs[k], ys[k], p, es[k]);
         end
         $display("signed a=%b b=%b product=%h", xs[k], ys[k], p);
      end
      for (int k = 0; k < 40; k++) begin
         logic [3:0] x, y;
         logic s;
         x = 4'($urandom_range(0, 15));
         y = 4'($urandom_range(0, 15));
         s = 1'($urandom_range(0, 1));
         run4(x, y, s, p, cyc);
         checks++;
         if (p !== model4(x, y, s) || cyc != 5) begin
            failures++;
            $display("FAIL signed_random a=%h b=%h sgn=%b product=%h cycle=%0d required %h",
                     x, y, s, p, cyc, model4(x, y, s));
         end
      end
   endtask

   task automatic test_ignore_start;
      int dones = 0;
      a4 = 4'd6; b4 = 4'd7; sgn4 = 1'b0; start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      @(negedge clk);
      a4 = 4'd1; b4 = 4'd1; start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      for (int c = 0; c < 12; c++) begin
         if (done4) dones++;
         @(negedge clk);
      end
      checks++;
      if (prod4 !== 8'h2A || dones != 1) begin
         failures++;
         $display("FAIL ignore_start product=%h dones=%0d required 2A dones=1", prod4, dones);
      end
      $display("ignore start 6x7 product=%h dones=%0d", prod4, dones);
   endtask

   task automatic test_back_to_back;
      logic [7:0] p;
      int cyc;
      run4(4'd5, 4'd5, 1'b0, p, cyc);
      checks++;
      if (p !== 8'h19 || done4 !== 1'b1) begin
         failures++;
         $display("FAIL b2b_first product=%h done=%b required 19 1", p, done4);
      end
      a4 = 4'd2; b4 = 4'd3; start4 = 1'b1;
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         start4 = 1'b0;
         checks++;
         if (prod4 !== 8'h19 || done4 !== 1'b0 || busy4 !== 1'b1) begin
            failures++;
            $display("FAIL b2b_hold cycle=%0d product=%h done=%b busy=%b required 19 0 1",
                     c, prod4, done4, busy4);
         end
      end
      @(negedge clk);
      checks++;
      if (prod4 !== 8'h06 || done4 !== 1'b1) begin
         failures++;
         $display("FAIL b2b_second product=%h done=%b required 06 1", prod4, done4);
      end
      $display("back-to-back 5x5 then 2x3 product=%h", prod4);
      @(negedge clk);
   endtask

   task automatic test_reset_abort;
      int dones = 0;
      a4 = 4'd9; b4 = 4'd9; sgn4 = 1'b0; start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++;
      if (busy4 !== 1'b0 || prod4 !== 8'h00) begin
         failures++;
         $display("FAIL reset_abort busy=%b product=%h required 0 00", busy4, prod4);
      end
      for (int c = 0; c < 10; c++) begin
         if (done4) dones++;
         @(negedge clk);
      end
      checks++;
      if (dones != 0) begin
         failures++;
         $display("FAIL reset_abort_done dones=%0d required 0", dones);
      end
      $display("reset abort busy=%b product=%h dones=%0d", busy4, prod4, dones);
   endtask

   task automatic test_reset_priority;
      reset = 1'b1; start4 = 1'b1; a4 = 4'd3; b4 = 4'd3;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         checks++;
         if (busy4 !== 1'b0 || done4 !== 1'b0) begin
            failures++;
            $display("FAIL reset_priority cycle=%0d busy=%b done=%b required 0 0", c, busy4, done4);
         end
      end
      start4 = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      $display("reset priority busy=%b", busy4);
   endtask

   task automatic test_w8;
      logic [15:0] p;
      int cyc;
      logic [7:0]  xs [3] = '{8'd255, 8'h80, 8'hFF};
      logic [7:0]  ys [3] = '{8'd255, 8'h80, 8'd127};
      logic        ss [3] = '{1'b0,   1'b1,  1'b1};
      logic [15:0] es [3] = '{16'hFE01, 16'h4000, 16'hFF81};
      for (int k = 0; k < 3; k++) begin
         run8(xs[k], ys[k], ss[k], p, cyc);
         checks++;
         if (p !== es[k] || cyc != 9) begin
            failures++;
            $display("FAIL w8_vector a=%h b=%h product=%h cycle=%0d required %h cycle=9",
                     xs[k], ys[k], p, cyc, es[k]);
         end
         $display("w8 a=%h b=%h sgn=%b product=%h", xs[k], ys[k], ss[k], p);
      end
      for (int k = 0; k < 40; k++) begin
         logic [7:0] x, y;
         logic s;
         x = 8'($urandom_range(0, 255));
         y = 8'($urandom_range(0, 255));
         s = 1'($urandom_range(0, 1));
         run8(x, y, s, p, cyc);
         checks++;
         if (p !== model8(x, y, s) || cyc != 9) begin
            failures++;
            $display("FAIL w8_random a=%h b=%h sgn=%b product=%h cycle=%0d required %h",
                     x, y, s, p, cyc, model8(x, y, s));
         end
      end
   endtask

   initial begin
      test_reset;
      test_latency;
      @(negedge clk);
      test_unsigned_sweep;
      test_signed;
      @(negedge clk);
      test_ignore_start;
      test_back_to_back;
      test_reset_abort;
      test_reset_priority;
      test_w8;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
